// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU; produces {remainder, quotient} for HI/LO.
// Optional DIV_EARLY_EXIT_EN: skips iterations when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
`ifdef DIV_EARLY_EXIT_EN
    S_EARLY,
`endif
    S_END
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WIDTH-1:0]   rem_q, rem_n;
  logic [WIDTH-1:0]   quo_q, quo_n;
  logic [WIDTH-1:0]   dsr_q, dsr_n;
  logic               neg_q, neg_n;
  logic               dsign_q, dsign_n;
  logic [2*WIDTH-1:0] result_q, result_n;
  logic               ready_q, ready_n;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_step, quo_step, q_fix, r_fix;

  // Operand magnitudes and one shift/trial-subtract step
  always_comb begin
    a_neg = signed_div_i & opdata1_i[WIDTH-1];
    b_neg = signed_div_i & opdata2_i[WIDTH-1];
    a_mag = a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    b_mag = b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
    q_fix = neg_q   ? (~quo_step + WIDTH'(1)) : quo_step;
    r_fix = dsign_q ? (~rem_step + WIDTH'(1)) : rem_step;
  end

  // Next-state and register-next logic
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    rem_n    = rem_q;
    quo_n    = quo_q;
    dsr_n    = dsr_q;
    neg_n    = neg_q;
    dsign_n  = dsign_q;
    result_n = result_q;
    ready_n  = ready_q;
    case (state_q)
      S_IDLE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          dsr_n   = b_mag;
          quo_n   = a_mag;
          rem_n   = '0;
          cnt_n   = '0;
          neg_n   = a_neg ^ b_neg;
          dsign_n = a_neg;
          if (opdata2_i == '0)
            state_n = S_DIVZERO;
`ifdef DIV_EARLY_EXIT_EN
          else if (a_mag < b_mag)
            state_n = S_EARLY;
`endif
          else
            state_n = S_ON;
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_END;
          result_n = '0;
          ready_n  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_n  = S_IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end else begin
          rem_n = rem_step;
          quo_n = quo_step;
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_n  = S_END;
            result_n = {r_fix, q_fix};
            ready_n  = 1'b1;
          end
        end
      end
`ifdef DIV_EARLY_EXIT_EN
      // Quotient is zero; remainder is the dividend with its sign restored
      S_EARLY: begin
        if (annul_i) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_END;
          result_n = {(dsign_q ? (~quo_q + WIDTH'(1)) : quo_q), {WIDTH{1'b0}}};
          ready_n  = 1'b1;
        end
      end
`endif
      S_END: begin
        if (annul_i || !start_i) begin
          state_n  = S_IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end
      default: begin
        state_n  = S_IDLE;
        ready_n  = 1'b0;
        result_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      neg_q    <= 1'b0;
      dsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      dsr_q    <= dsr_n;
      neg_q    <= neg_n;
      dsign_q  <= dsign_n;
      result_q <= result_n;
      ready_q  <= ready_n;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = start_i & ~ready_q;

endmodule
